// File: rtl/byte_unstrip_n.sv
// byte_unstrip_n: serialises one NUM_LANES lane group per handshake onto a single symbol stream, lane 0 first
module byte_unstrip_n #(
   parameter int NUM_LANES = 4,
   parameter int WIDTH = 8,
   parameter logic [WIDTH-1:0] STP_SYM = 8'hfb,
   parameter logic [WIDTH-1:0] SDP_SYM = 8'h5c,
   localparam int CW = $clog2(NUM_LANES) + 1,
   localparam int IW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic                       IN_VALID,
   output logic                       IN_READY,
   input  logic [NUM_LANES*WIDTH-1:0] LANE_D,
   input  logic [NUM_LANES-1:0]       LANE_K,
   input  logic [CW-1:0]              ACT_LANES,
   output logic [WIDTH-1:0]           D,
   output logic                       DK,
   output logic                       OUT_VALID,
   input  logic                       OUT_READY,
   output logic                       FRAME_START
);
   typedef enum logic {IDLE, DRAIN} state_t;
   state_t state_q, state_d;
   logic [NUM_LANES-1:0][WIDTH-1:0] grp_d_q, grp_d_d;
   logic [NUM_LANES-1:0] grp_k_q, grp_k_d;
   logic [CW-1:0] cnt_q, cnt_d, act_cnt;
   logic [IW-1:0] idx_q, idx_d;
   logic last, accept, emit;
   always_comb begin
      last = CW'(idx_q) == cnt_q - CW'(1);
      OUT_VALID = state_q == DRAIN;
      IN_READY = !OUT_VALID || (OUT_READY && last);
      accept = IN_VALID && IN_READY;
      emit = OUT_VALID && OUT_READY;
      act_cnt = (ACT_LANES == '0 || ACT_LANES > CW'(NUM_LANES)) ? CW'(NUM_LANES) : ACT_LANES;
      state_d = accept ? DRAIN : (emit && last) ? IDLE : state_q;
      idx_d = accept ? '0 : (emit && !last) ? idx_q + IW'(1) : idx_q;
      cnt_d = accept ? act_cnt : cnt_q;
      grp_d_d = accept ? LANE_D : grp_d_q;
      grp_k_d = accept ? LANE_K : grp_k_q;
      D = grp_d_q[idx_q];
      DK = grp_k_q[idx_q];
      FRAME_START = OUT_VALID && DK && (D == STP_SYM || D == SDP_SYM);
   end
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         idx_q <= '0;
         cnt_q <= CW'(NUM_LANES);
         grp_d_q <= '0;
         grp_k_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         cnt_q <= cnt_d;
         grp_d_q <= grp_d_d;
         grp_k_q <= grp_k_d;
      end
   end
endmodule

// File: tb/tb_byte_unstrip_n.sv
// tb_byte_unstrip_n: directed vector table plus a reset-mid-group sequence for byte_unstrip_n
module tb_byte_unstrip_n;
   logic clk = 0, reset = 1, in_valid = 0, in_ready, dk, out_valid, out_ready = 1, frame_start;
   logic [31:0] lane_d = 0;
   logic [3:0] lane_k = 0;
   logic [2:0] act_lanes = 4;
   logic [7:0] d;
   int checks = 0, failures = 0;
   typedef struct {
      logic vin; logic [31:0] ld; logic [3:0] lk; logic [2:0] act; logic ordy;
      logic [7:0] d; logic dk; logic ov; logic fs; logic ir;
   } vec_t;
   vec_t tbl[33];
   always #5 clk = ~clk;
   byte_unstrip_n dut (
      .CLK(clk), .RESET(reset), .IN_VALID(in_valid), .IN_READY(in_ready), .LANE_D(lane_d),
      .LANE_K(lane_k), .ACT_LANES(act_lanes), .D(d), .DK(dk), .OUT_VALID(out_valid),
      .OUT_READY(out_ready), .FRAME_START(frame_start)
   );
   task automatic check(input string name, input int step, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, step, got, exp);
      end
   endtask
   task automatic run_vec(input vec_t v, input int step);
      in_valid = v.vin; lane_d = v.ld; lane_k = v.lk; act_lanes = v.act; out_ready = v.ordy;
      @(negedge clk);
      check("D", step, 32'(d), 32'(v.d));
      check("DK", step, 32'(dk), 32'(v.dk));
      check("OUT_VALID", step, 32'(out_valid), 32'(v.ov));
      check("FRAME_START", step, 32'(frame_start), 32'(v.fs));
      check("IN_READY", step, 32'(in_ready), 32'(v.ir));
      @(posedge clk); #1;
   endtask
   initial begin
      tbl[0]  = '{0, 0, 0, 4, 1, 8'h00, 0, 0, 0, 1};
      tbl[1]  = '{1, 32'h030201fb, 4'b0001, 4, 1, 8'h00, 0, 0, 0, 1};
      tbl[2]  = '{0, 0, 0, 4, 1, 8'hfb, 1, 1, 1, 0};
      tbl[3]  = '{0, 0, 0, 4, 1, 8'h01, 0, 1, 0, 0};
      tbl[4]  = '{0, 0, 0, 4, 1, 8'h02, 0, 1, 0, 0};
      tbl[5]  = '{1, 32'h13121110, 0, 4, 1, 8'h03, 0, 1, 0, 1};
      tbl[6]  = '{1, 32'h23222120, 0, 4, 1, 8'h10, 0, 1, 0, 0};
      tbl[7]  = '{1, 32'h23222120, 0, 4, 1, 8'h11, 0, 1, 0, 0};
      tbl[8]  = '{1, 32'h23222120, 0, 4, 1, 8'h12, 0, 1, 0, 0};
      tbl[9]  = '{1, 32'h23222120, 0, 4, 1, 8'h13, 0, 1, 0, 1};
      tbl[10] = '{0, 0, 0, 4, 1, 8'h20, 0, 1, 0, 0};
      tbl[11] = '{0, 0, 0, 4, 0, 8'h21, 0, 1, 0, 0};
      tbl[12] = '{0, 0, 0, 4, 0, 8'h21, 0, 1, 0, 0};
      tbl[13] = '{0, 0, 0, 4, 0, 8'h21, 0, 1, 0, 0};
      tbl[14] = '{0, 0, 0, 4, 1, 8'h21, 0, 1, 0, 0};
      tbl[15] = '{0, 0, 0, 4, 1, 8'h22, 0, 1, 0, 0};
      tbl[16] = '{1, 32'h33323130, 0, 2, 0, 8'h23, 0, 1, 0, 0};
      tbl[17] = '{1, 32'h33323130, 0, 2, 1, 8'h23, 0, 1, 0, 1};
      tbl[18] = '{0, 0, 0, 4, 1, 8'h30, 0, 1, 0, 0};
      tbl[19] = '{1, 32'h43424140, 0, 0, 1, 8'h31, 0, 1, 0, 1};
      tbl[20] = '{0, 0, 0, 1, 1, 8'h40, 0, 1, 0, 0};
      tbl[21] = '{0, 0, 0, 1, 1, 8'h41, 0, 1, 0, 0};
      tbl[22] = '{0, 0, 0, 1, 1, 8'h42, 0, 1, 0, 0};
      tbl[23] = '{1, 32'h53525150, 0, 5, 1, 8'h43, 0, 1, 0, 1};
      tbl[24] = '{0, 0, 0, 2, 1, 8'h50, 0, 1, 0, 0};
      tbl[25] = '{0, 0, 0, 2, 1, 8'h51, 0, 1, 0, 0};
      tbl[26] = '{0, 0, 0, 2, 1, 8'h52, 0, 1, 0, 0};
      tbl[27] = '{1, 32'hfb5c7c7c, 4'b0101, 4, 1, 8'h53, 0, 1, 0, 1};
      tbl[28] = '{0, 0, 0, 4, 1, 8'h7c, 1, 1, 0, 0};
      tbl[29] = '{0, 0, 0, 4, 1, 8'h7c, 0, 1, 0, 0};
      tbl[30] = '{0, 0, 0, 4, 1, 8'h5c, 1, 1, 1, 0};
      tbl[31] = '{0, 0, 0, 4, 1, 8'hfb, 0, 1, 0, 1};
      tbl[32] = '{0, 0, 0, 4, 1, 8'hfb, 0, 0, 0, 1};
      repeat (2) @(posedge clk);
      #1 reset = 0;
      for (int i = 0; i < 33; i++) run_vec(tbl[i], i);
      run_vec('{1, 32'h63626160, 0, 4, 1, 8'hfb, 0, 0, 0, 1}, 100);
      run_vec('{0, 0, 0, 4, 1, 8'h60, 0, 1, 0, 0}, 101);
      run_vec('{0, 0, 0, 4, 1, 8'h61, 0, 1, 0, 0}, 102);
      reset = 1;
      run_vec('{1, 32'h83828180, 4'b1111, 4, 1, 8'h62, 0, 1, 0, 0}, 103);
      reset = 0;
      run_vec('{0, 0, 0, 4, 1, 8'h00, 0, 0, 0, 1}, 104);
      run_vec('{1, 32'h73727170, 0, 4, 1, 8'h00, 0, 0, 0, 1}, 105);
      run_vec('{0, 0, 0, 4, 1, 8'h70, 0, 1, 0, 0}, 106);
      run_vec('{0, 0, 0, 4, 1, 8'h71, 0, 1, 0, 0}, 107);
      run_vec('{0, 0, 0, 4, 1, 8'h72, 0, 1, 0, 0}, 108);
      run_vec('{0, 0, 0, 4, 1, 8'h73, 0, 1, 0, 1}, 109);
      run_vec('{0, 0, 0, 4, 1, 8'h73, 0, 0, 0, 1}, 110);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
